writeback_arbiter: RTL
======================

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3: number of write-port requesters (0=ALU, 1=load, 2=mul/div).
REQ-002 SHALL have parameter DATA_WIDTH, default 32: register write data width.
REQ-003 SHALL have parameter REG_WIDTH, default 5: register index width.
REQ-004 SHALL have port clock  input  1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1: asynchronous, active-low reset (asserted at 0).
REQ-006 SHALL have port req_valid  input  NUM_REQ: requester i offers a write.
REQ-007 SHALL have port req_ready  output  NUM_REQ: requester i's offer is accepted this edge.
REQ-008 SHALL have port req_data  input  NUM_REQ*DATA_WIDTH: write data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port req_reg  input  NUM_REQ*REG_WIDTH: destination register; requester i occupies bits [i*REG_WIDTH +: REG_WIDTH].
REQ-010 SHALL have port hold  input  1: suppresses all grants while high.
REQ-011 SHALL have port output_write_enable  output  1: register-file write strobe.
REQ-012 SHALL have port output_write_data  output  DATA_WIDTH: register-file write data.
REQ-013 SHALL have port output_write_reg  output  REG_WIDTH: register-file write index.
REQ-014 SHALL have port pending_mask  output  NUM_REQ: slot_full per requester, for hazard logic.

Function
REQ-015 SHALL keep one holding slot (valid, data, reg) per requester.
REQ-016 SHALL accept (handshake) on an edge where req_valid[i] and req_ready[i] are both high, loading slot i.
REQ-017 SHALL drive req_ready[i] = !slot_full[i] | grant[i], allowing same-edge drain and refill.
REQ-018 SHALL, when hold=0, grant exactly one full slot per cycle, round-robin starting at pointer rr_ptr.
REQ-019 SHALL set rr_ptr to (granted index + 1) mod NUM_REQ after each grant; SHALL leave it unchanged when no grant is made.
REQ-020 SHALL register the granted slot into output_write_* on the grant edge, giving a one-cycle latency from the acceptance edge to output_write_enable=1.
REQ-021 SHALL deassert output_write_enable, and drive output_write_data and output_write_reg to 0, in any cycle following an edge with no grant.
REQ-022 SHALL treat a granted slot whose reg is 0 as consumed, and SHALL drive output_write_enable=0 and output_write_data=0 in the following cycle.
REQ-023 SHALL, while hold=1: make no grant, keep every slot unchanged, and keep req_ready[i] = !slot_full[i].
REQ-024 SHALL never drop or duplicate an accepted request; each accepted request produces exactly one grant.
REQ-025 SHALL bound the wait of any full slot, with hold=0, to at most NUM_REQ-1 cycles.

Reset
REQ-026 SHALL, on reset=0 (immediately, asynchronously): clear all slot_full bits, set rr_ptr=0, and set output_write_enable, output_write_data and output_write_reg to 0.
REQ-027 SHALL discard requests accepted before reset; none of them may appear after reset is released.
REQ-028 SHALL hold req_ready at 0 while reset is asserted.

Structure
REQ-029 SHALL take the NUM_REQ, DATA_WIDTH and REG_WIDTH defaults and the requester index constants from the shared CPU package.
REQ-030 SHALL implement the round-robin selection as sub-module rr_arbiter (inputs: request mask and pointer; outputs: one-hot grant and grant index).

Verification
REQ-031 SHALL cover: single request, ALU reg 8 data 0x12345678 -> output_write_enable=1, reg 8, data 0x12345678 one cycle after acceptance.
REQ-032 SHALL cover: all three requesters accepted on the same edge with rr_ptr=0 -> outputs in order 0,1,2 on consecutive cycles; rr_ptr ends at 0.
REQ-033 SHALL cover: requester 1 streaming back-to-back against idle others -> one write per cycle, req_ready[1] held at 1.
REQ-034 SHALL cover: hold=1 for 4 cycles with slots 0 and 2 full -> no writes, req_ready=3'b010; after hold falls, writes from slot 0 then slot 2.
REQ-035 SHALL cover: load to reg 0, data 0xDEADBEEF -> slot consumed, output_write_enable stays 0.
REQ-036 SHALL cover: reset asserted mid-cycle with 2 slots full -> outputs 0 immediately; after release, no stale writes.

Source files
------------

// File: rtl/writeback_arbiter_pkg.sv
// Shared CPU constants for the register-file writeback path: port widths and
// the fixed requester slot assignment.
package writeback_arbiter_pkg;

    localparam int WB_NUM_REQ    = 3;
    localparam int WB_DATA_WIDTH = 32;
    localparam int WB_REG_WIDTH  = 5;

    localparam int REQ_ALU    = 0;
    localparam int REQ_LOAD   = 1;
    localparam int REQ_MULDIV = 2;

    typedef enum logic [1:0] {
        ID_ALU    = 2'd0,
        ID_LOAD   = 2'd1,
        ID_MULDIV = 2'd2
    } req_id_e;

endpackage

// File: rtl/writeback_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set bit of req at or after ptr,
// wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx,
    output logic               grant_any
);

    logic [PTR_W:0]   pos;
    logic [PTR_W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        pos       = '0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // ptr is always < NUM_REQ, so one subtraction wraps correctly
            pos = {1'b0, ptr} + (PTR_W+1)'(k);
            if (pos >= (PTR_W+1)'(NUM_REQ))
                pos = pos - (PTR_W+1)'(NUM_REQ);
            idx = pos[PTR_W-1:0];
            if (!grant_any && req[idx]) begin
                grant_any  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Register-file write-port arbiter: one holding slot per requester, one
// round-robin grant per cycle, registered write outputs.
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = WB_NUM_REQ,
    parameter int DATA_WIDTH = WB_DATA_WIDTH,
    parameter int REG_WIDTH  = WB_REG_WIDTH
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ*REG_WIDTH-1:0]  req_reg,
    input  logic                          hold,
    output logic                          output_write_enable,
    output logic [DATA_WIDTH-1:0]         output_write_data,
    output logic [REG_WIDTH-1:0]          output_write_reg,
    output logic [NUM_REQ-1:0]            pending_mask
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] in_data;
    logic [NUM_REQ-1:0][REG_WIDTH-1:0]  in_reg;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] slot_data;
    logic [NUM_REQ-1:0][REG_WIDTH-1:0]  slot_reg;
    logic [NUM_REQ-1:0]                 slot_full;
    logic [NUM_REQ-1:0]                 req_mask;
    logic [NUM_REQ-1:0]                 grant;
    logic [NUM_REQ-1:0]                 accept;
    logic [PTR_W-1:0]                   rr_ptr;
    logic [PTR_W-1:0]                   grant_idx;
    logic [PTR_W-1:0]                   next_ptr;
    logic                               grant_any;
    logic [DATA_WIDTH-1:0]              sel_data;
    logic [REG_WIDTH-1:0]               sel_reg;

    assign in_data = req_data;
    assign in_reg  = req_reg;

    // hold hides every slot from the arbiter, so nothing drains or rotates
    assign req_mask = hold ? '0 : slot_full;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .req       (req_mask),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // a slot being drained this edge may be refilled on the same edge
    assign req_ready    = reset ? (~slot_full | grant) : '0;
    assign accept       = req_valid & req_ready;
    assign pending_mask = slot_full;

    assign sel_data = slot_data[grant_idx];
    assign sel_reg  = slot_reg[grant_idx];
    assign next_ptr = (grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            slot_full <= '0;
            slot_data <= '0;
            slot_reg  <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (accept[i]) begin
                    slot_full[i] <= 1'b1;
                    slot_data[i] <= in_data[i];
                    slot_reg[i]  <= in_reg[i];
                end else if (grant[i]) begin
                    slot_full[i] <= 1'b0;
                end
            end
        end
    end

    // writes to register 0 are consumed silently
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr              <= '0;
            output_write_enable <= 1'b0;
            output_write_data   <= '0;
            output_write_reg    <= '0;
        end else if (grant_any) begin
            rr_ptr              <= next_ptr;
            output_write_enable <= (sel_reg != '0);
            output_write_data   <= (sel_reg != '0) ? sel_data : '0;
            output_write_reg    <= sel_reg;
        end else begin
            output_write_enable <= 1'b0;
            output_write_data   <= '0;
            output_write_reg    <= '0;
        end
    end

endmodule
